// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide controller: operation codes,
// FSM states and a classifier for the multi-cycle operations.
package md_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic for mult/multu/div/divu, including the
// divide-by-zero and signed-overflow results.
module md_calc
  import md_ctrl_pkg::*;
(
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [2:0]  md_op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u     = {32'd0, rs_val} * {32'd0, rt_val};
    signed_div = (md_op == MD_DIV);
    // Divide magnitudes, then restore signs. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    num        = (signed_div && rs_val[31]) ? -rs_val : rs_val;
    den        = (signed_div && rt_val[31]) ? -rt_val : rt_val;
    den_safe   = (rt_val == 32'd0) ? 32'd1 : den;
    quo        = num / den_safe;
    rem        = num % den_safe;
    quo_fix    = (signed_div && (rs_val[31] ^ rt_val[31])) ? -quo : quo;
    rem_fix    = (signed_div && rs_val[31]) ? -rem : rem;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (rt_val == 32'd0) begin
          res_hi = rs_val;
          res_lo = 32'hffff_ffff;
        end else begin
          res_hi = rem_fix;
          res_lo = quo_fix;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy counter, HI/LO ownership
// and the D-stage stall request.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        hi_reg, hi_next;
  logic [31:0]        lo_reg, lo_next;
  logic [31:0]        pend_hi_reg, pend_hi_next;
  logic [31:0]        pend_lo_reg, pend_lo_next;
  logic [31:0]        res_hi, res_lo;
  logic               is_mul;

  md_calc u_calc (
    .rs_val (rs_val),
    .rt_val (rt_val),
    .md_op  (md_op),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= MD_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    is_mul       = (md_op == MD_MULT) || (md_op == MD_MULTU);
    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          if (is_long_op(md_op)) begin
            pend_hi_next = res_hi;
            pend_lo_next = res_lo;
            cnt_next     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_next   = MD_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_next = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_next = rs_val;
          end
        end
      end
      MD_RUN: begin
        // Any start seen here is dropped; the stall should have prevented it.
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          hi_next    = pend_hi_reg;
          lo_next    = pend_lo_reg;
          state_next = MD_IDLE;
        end
      end
    endcase
  end

  assign busy  = (state_reg == MD_RUN);
  assign stall = md_use_d & (busy | (start & is_long_op(md_op)));
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule
